// File: rtl/conv_pkg.sv
// Shared types and constants for the 5x5 convolution layer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // The kernel has exactly five row inputs, so the window size is fixed.
    localparam int KERNEL_K   = 5;
    localparam int NUM_W      = KERNEL_K * KERNEL_K;
    localparam int BIAS_ADDR  = KERNEL_K * KERNEL_K;

    // Geometry of the default 28x28 layer.
    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int OW         = DEF_IMG_W - KERNEL_K + 1;
    localparam int OH         = DEF_IMG_H - KERNEL_K + 1;
    localparam int TOTAL_COLS = OH * DEF_IMG_W;

endpackage

// File: rtl/conv_result_sink.sv
// Collects kernel results, drops row-straddling windows, writes the rest to result RAM in raster order.
// Latency: 1 cycle from k_out_valid to res_wr_en.
// Backpressure: none; every accepted kernel result is consumed the cycle it arrives.
//
// Ports: clr zeroes the per-pass counters; active enables collection (FEED/DRAIN);
// drained is high once TOTAL results have been received this pass.
// Build option CONV_RELU_EN: negative results are written as zero.
module conv_result_sink
    import conv_pkg::*;
#(
    parameter int DW     = 32,
    parameter int K      = KERNEL_K,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int RES_AW = 10,
    parameter int TOTAL  = TOTAL_COLS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              active,
    input  logic [DW-1:0]     k_d_out,
    input  logic              k_out_valid,
    output logic              drained,
    output logic              res_wr_en,
    output logic [RES_AW-1:0] res_wr_addr,
    output logic [DW-1:0]     res_wr_data
);

    localparam int OCW = $clog2(IMG_W);
    localparam int RCW = $clog2(TOTAL + 1);

    logic [OCW-1:0]    oc;
    logic [RES_AW-1:0] wr_cnt;
    logic [RCW-1:0]    rcv_cnt;
    logic              take;
    logic              keep;
    logic [DW-1:0]     wdata;

    assign drained = (rcv_cnt == RCW'(TOTAL));
    // Results past the issued count are strays and must not move any counter.
    assign take    = active && k_out_valid && !drained;
    // The first K-1 windows of every input row still contain columns of the previous row.
    assign keep    = take && (oc >= OCW'(K - 1));

`ifdef CONV_RELU_EN
    assign wdata = k_d_out[DW-1] ? '0 : k_d_out;
`else
    assign wdata = k_d_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc          <= '0;
            wr_cnt      <= '0;
            rcv_cnt     <= '0;
            res_wr_en   <= 1'b0;
            res_wr_addr <= '0;
            res_wr_data <= '0;
        end else begin
            res_wr_en <= keep;
            if (keep) begin
                res_wr_addr <= wr_cnt;
                res_wr_data <= wdata;
            end
            if (clr) begin
                oc      <= '0;
                wr_cnt  <= '0;
                rcv_cnt <= '0;
            end else if (take) begin
                oc      <= (oc == OCW'(IMG_W - 1)) ? '0 : oc + OCW'(1);
                rcv_cnt <= rcv_cnt + RCW'(1);
                if (keep) begin
                    wr_cnt <= wr_cnt + RES_AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Sequencer for one 5x5 conv kernel: weight/bias load, column-wise 5-row feature-map streaming, result write-back.
// Latency: 26 read cycles + 2 for weights, then one kernel column every 5 cycles; done 2 cycles after the last kernel result.
// Backpressure: none; RAMs have fixed 1-cycle read latency and the kernel accepts a column at any spacing.
//
// Ports: start/busy/done pass control; fm_rd_* and wt_rd_* RAM read ports (data one cycle after enable);
// k_d_in1..5, k_in_valid, k_w_in, k_b_in drive the kernel; k_d_out/k_out_valid return results;
// res_wr_* write result RAM. Build option CONV_RELU_EN (in conv_result_sink) clamps negative results to 0.
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int DW     = 32,
    parameter int K      = KERNEL_K,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int FM_AW  = 10,
    parameter int WT_AW  = 5,
    parameter int RES_AW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fm_rd_en,
    output logic [FM_AW-1:0]   fm_rd_addr,
    input  logic [DW-1:0]      fm_rd_data,
    output logic               wt_rd_en,
    output logic [WT_AW-1:0]   wt_rd_addr,
    input  logic [DW-1:0]      wt_rd_data,
    output logic [DW-1:0]      k_d_in1,
    output logic [DW-1:0]      k_d_in2,
    output logic [DW-1:0]      k_d_in3,
    output logic [DW-1:0]      k_d_in4,
    output logic [DW-1:0]      k_d_in5,
    output logic               k_in_valid,
    output logic [K*K*DW-1:0]  k_w_in,
    output logic [DW-1:0]      k_b_in,
    input  logic [DW-1:0]      k_d_out,
    input  logic               k_out_valid,
    output logic               res_wr_en,
    output logic [RES_AW-1:0]  res_wr_addr,
    output logic [DW-1:0]      res_wr_data
);

    localparam int ROWS_OUT   = IMG_H - K + 1;
    localparam int COLS_TOTAL = ROWS_OUT * IMG_W;

    localparam logic [WT_AW-1:0] WT_BIAS     = WT_AW'(BIAS_ADDR);
    localparam logic [WT_AW-1:0] WT_END      = WT_AW'(BIAS_ADDR + 1);
    localparam logic [FM_AW-1:0] ROW_STEP    = FM_AW'(IMG_W);
    localparam logic [FM_AW-1:0] LAST_COL    = FM_AW'(IMG_W - 1);
    localparam logic [FM_AW-1:0] LAST_RB     = FM_AW'((ROWS_OUT - 1) * IMG_W);

    state_t            state_q;
    state_t            state_d;
    logic              start_acc;
    logic              feed_last;
    logic              drained;
    logic              sink_active;

    logic [WT_AW-1:0]  wt_cnt;
    logic              wt_vld_q;
    logic [WT_AW-1:0]  wt_idx_q;

    // fm address = row_base (r*IMG_W) + off (i*IMG_W) + col; kept additive to avoid multipliers.
    logic [FM_AW-1:0]  row_base;
    logic [FM_AW-1:0]  off;
    logic [FM_AW-1:0]  col;
    logic [2:0]        row_i;
    logic              fm_vld_q;
    logic [2:0]        fm_idx_q;

    assign wt_rd_addr = wt_cnt;
    assign fm_rd_addr = row_base + off + col;
    assign feed_last  = (row_i == 3'd4) && (col == LAST_COL) && (row_base == LAST_RB);
    assign sink_active = (state_q == FEED) || (state_q == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        wt_rd_en  = 1'b0;
        fm_rd_en  = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = LOAD_W;
                end
            end
            LOAD_W: begin
                busy     = 1'b1;
                wt_rd_en = (wt_cnt != WT_END);
                // wt_cnt == WT_END is the cycle the bias word is on the bus and captured.
                if (wt_cnt == WT_END) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                busy     = 1'b1;
                fm_rd_en = 1'b1;
                if (feed_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drained) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Weight/bias load: 26 back-to-back reads, each word captured the cycle after its read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_cnt   <= '0;
            wt_vld_q <= 1'b0;
            wt_idx_q <= '0;
            k_w_in   <= '0;
            k_b_in   <= '0;
        end else begin
            if (state_q == LOAD_W) begin
                wt_cnt <= (wt_cnt == WT_END) ? '0 : wt_cnt + WT_AW'(1);
            end
            wt_vld_q <= wt_rd_en;
            wt_idx_q <= wt_cnt;
            if (wt_vld_q) begin
                if (wt_idx_q == WT_BIAS) begin
                    k_b_in <= wt_rd_data;
                end else begin
                    for (int j = 0; j < NUM_W; j++) begin
                        if (wt_idx_q == WT_AW'(j)) begin
                            k_w_in[j*DW +: DW] <= wt_rd_data;
                        end
                    end
                end
            end
        end
    end

    // Feature-map walk: rows i=0..4 of column col, then next column, then next output row.
    // All counters wrap back to zero after the final read, ready for the next pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
            off      <= '0;
            col      <= '0;
            row_i    <= '0;
        end else if (state_q == FEED) begin
            if (row_i == 3'd4) begin
                row_i <= '0;
                off   <= '0;
                if (col == LAST_COL) begin
                    col      <= '0;
                    row_base <= feed_last ? '0 : row_base + ROW_STEP;
                end else begin
                    col <= col + FM_AW'(1);
                end
            end else begin
                row_i <= row_i + 3'd1;
                off   <= off + ROW_STEP;
            end
        end
    end

    // Capture returning pixels; the column strobe follows the row-4 capture so all five
    // kernel inputs are stable while it is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_vld_q   <= 1'b0;
            fm_idx_q   <= '0;
            k_in_valid <= 1'b0;
            k_d_in1    <= '0;
            k_d_in2    <= '0;
            k_d_in3    <= '0;
            k_d_in4    <= '0;
            k_d_in5    <= '0;
        end else begin
            fm_vld_q   <= fm_rd_en;
            fm_idx_q   <= row_i;
            k_in_valid <= fm_vld_q && (fm_idx_q == 3'd4);
            if (fm_vld_q) begin
                case (fm_idx_q)
                    3'd0:    k_d_in1 <= fm_rd_data;
                    3'd1:    k_d_in2 <= fm_rd_data;
                    3'd2:    k_d_in3 <= fm_rd_data;
                    3'd3:    k_d_in4 <= fm_rd_data;
                    default: k_d_in5 <= fm_rd_data;
                endcase
            end
        end
    end

    conv_result_sink #(
        .DW     (DW),
        .K      (K),
        .IMG_W  (IMG_W),
        .RES_AW (RES_AW),
        .TOTAL  (COLS_TOTAL)
    ) u_sink (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (start_acc),
        .active      (sink_active),
        .k_d_out     (k_d_out),
        .k_out_valid (k_out_valid),
        .drained     (drained),
        .res_wr_en   (res_wr_en),
        .res_wr_addr (res_wr_addr),
        .res_wr_data (res_wr_data)
    );

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl on an 8x8 map with a behavioural kernel and RAM models.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_layer_ctrl;

    localparam int DW = 32, K = 5, IW = 8, IH = 8;
    localparam int FM_AW = 10, WT_AW = 5, RES_AW = 10;
    localparam int OW = IW - K + 1, OH = IH - K + 1, TOT = OH * IW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, fm_rd_en, wt_rd_en, k_in_valid, k_out_valid, res_wr_en;
    logic [FM_AW-1:0]  fm_rd_addr;
    logic [WT_AW-1:0]  wt_rd_addr;
    logic [DW-1:0]     fm_rd_data, wt_rd_data;
    logic [DW-1:0]     k_d_in1, k_d_in2, k_d_in3, k_d_in4, k_d_in5, k_b_in, k_d_out;
    logic [K*K*DW-1:0] k_w_in;
    logic [RES_AW-1:0] res_wr_addr;
    logic [DW-1:0]     res_wr_data;

    always #5 clk = ~clk;

    conv_layer_ctrl #(
        .DW(DW), .K(K), .IMG_W(IW), .IMG_H(IH),
        .FM_AW(FM_AW), .WT_AW(WT_AW), .RES_AW(RES_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .k_d_in1(k_d_in1), .k_d_in2(k_d_in2), .k_d_in3(k_d_in3), .k_d_in4(k_d_in4), .k_d_in5(k_d_in5),
        .k_in_valid(k_in_valid), .k_w_in(k_w_in), .k_b_in(k_b_in),
        .k_d_out(k_d_out), .k_out_valid(k_out_valid),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef CONV_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // RAM models: one-cycle read latency.
    logic [DW-1:0] fm_mem [IW*IH];
    logic [DW-1:0] wt_mem [K*K+1];
    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= fm_mem[int'(fm_rd_addr) % (IW*IH)];
        if (wt_rd_en) wt_rd_data <= wt_mem[int'(wt_rd_addr) % (K*K+1)];
    end

    // Kernel model, latency 3. mode 0: 0x100 + input column index; mode 1: true 5x5
    // convolution over the last five columns; mode 2: constant negative value.
    int            kmode = 0;
    bit            inject_extra = 0;
    logic          stray = 1'b0;
    logic          extra;
    logic          pv [3];
    logic [DW-1:0] pd [3];
    logic [DW-1:0] colbuf [5][5];
    int            kcidx, kout_n;

    assign k_out_valid = pv[2] | stray | extra;
    assign k_d_out     = pd[2];

    always @(posedge clk or negedge rst_n) begin
        logic [DW-1:0] res;
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin pv[s] <= 1'b0; pd[s] <= '0; end
            for (int c = 0; c < 5; c++) for (int r = 0; r < 5; r++) colbuf[c][r] = '0;
            kcidx = 0;
            kout_n <= 0;
            extra <= 1'b0;
        end else begin
            res = '0;
            if (k_in_valid) begin
                for (int c = 0; c < 4; c++) for (int r = 0; r < 5; r++) colbuf[c][r] = colbuf[c+1][r];
                colbuf[4][0] = k_d_in1; colbuf[4][1] = k_d_in2; colbuf[4][2] = k_d_in3;
                colbuf[4][3] = k_d_in4; colbuf[4][4] = k_d_in5;
                case (kmode)
                    0: res = 32'h100 + DW'(kcidx);
                    1: begin
                        res = k_b_in;
                        for (int i = 0; i < 5; i++)
                            for (int j = 0; j < 5; j++)
                                res = res + k_w_in[(i*5+j)*DW +: DW] * colbuf[j][i];
                    end
                    default: res = 32'hFFFF_FFF6;
                endcase
                kcidx = (kcidx + 1) % IW;
            end
            pv[0] <= k_in_valid; pd[0] <= res;
            pv[1] <= pv[0];      pd[1] <= pd[0];
            pv[2] <= pv[1];      pd[2] <= pd[1];
            // One extra strobe right after the last real result of a pass.
            extra <= inject_extra && pv[2] && ((kout_n % TOT) == TOT - 1);
            if (pv[2]) kout_n <= kout_n + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and event monitors.
    logic [RES_AW+DW-1:0] exp_q [$];
    int wt_n = 0, kin_n = 0, wr_n = 0, done_n = 0;
    int pass_id = 0;
    int seen_pass = 0, kin_rel = 0, kin_cyc0 = 0, widx = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_wr_en) begin
                wr_n++;
                if (exp_q.size() == 0) fail("res_wr_unexpected");
                else chk("res_wr addr_data", {res_wr_addr, res_wr_data}, exp_q.pop_front());
            end
            if (wt_rd_en) begin
                chk("wt_rd_addr", 64'(wt_rd_addr), 64'(widx));
                widx++;
                wt_n++;
            end else begin
                widx = 0;
            end
            if (k_in_valid) begin
                if (seen_pass != pass_id) begin
                    seen_pass = pass_id;
                    kin_rel = 0;
                    for (int j = 0; j < K*K; j++)
                        chk($sformatf("k_w_in[%0d]", j), 64'(k_w_in[j*DW +: DW]), 64'(wt_mem[j]));
                    chk("k_b_in", 64'(k_b_in), 64'(wt_mem[K*K]));
                end
                if (pass_id == 1 && kin_rel < 2) begin
                    for (int i = 0; i < 5; i++) begin
                        logic [DW-1:0] got;
                        case (i)
                            0: got = k_d_in1; 1: got = k_d_in2; 2: got = k_d_in3;
                            3: got = k_d_in4; default: got = k_d_in5;
                        endcase
                        chk($sformatf("feed col%0d row%0d", kin_rel, i), 64'(got), 64'(i*IW + kin_rel));
                    end
                    if (kin_rel == 0) kin_cyc0 = cyc;
                    else chk("feed column spacing", 64'(cyc - kin_cyc0), 64'd5);
                end
                kin_rel++;
                kin_n++;
            end
            if (done) begin
                done_n++;
                chk("busy low in done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic push_expected();
        for (int y = 0; y < OH; y++) begin
            for (int x = 0; x < OW; x++) begin
                logic [DW-1:0] v;
                case (kmode)
                    0: v = 32'h100 + DW'(x + K - 1);
                    1: begin
                        v = wt_mem[K*K];
                        for (int i = 0; i < K; i++)
                            for (int j = 0; j < K; j++)
                                v = v + wt_mem[i*K+j] * fm_mem[(y+i)*IW + x + j];
                    end
                    default: v = 32'hFFFF_FFF6;
                endcase
                exp_q.push_back({RES_AW'(y*OW + x), relu(v)});
            end
        end
    endtask

    task automatic pulse(input bit is_start);
        @(negedge clk);
        if (is_start) start = 1'b1; else stray = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stray = 1'b0;
    endtask

    task automatic wait_kin(input int base, input int n);
        bit ok = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (kin_n - base >= n) begin ok = 1; break; end
        end
        if (!ok) fail("timeout waiting for k_in_valid");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " done"}, 64'(done), 0);
        chk({tag, " strobes"}, {60'd0, wt_rd_en, fm_rd_en, k_in_valid, res_wr_en}, 0);
        chk({tag, " addrs"}, {34'd0, fm_rd_addr, wt_rd_addr, res_wr_addr}, 0);
        chk({tag, " res_wr_data"}, 64'(res_wr_data), 0);
        chk({tag, " k_b_in"}, 64'(k_b_in), 0);
        chk({tag, " k_w_in nonzero"}, 64'(k_w_in != '0), 0);
        chk({tag, " k_d_in"}, 64'(k_d_in1 | k_d_in2 | k_d_in3 | k_d_in4 | k_d_in5), 0);
    endtask

    // Full pass: optional strays in IDLE/LOAD_W and a redundant start mid-FEED.
    task automatic run_pass(input bit extras);
        int wt0, kin0, wr0, done0;
        bit ok;
        wt0 = wt_n; kin0 = kin_n; wr0 = wr_n; done0 = done_n;
        pass_id++;
        push_expected();
        if (extras) pulse(0);
        pulse(1);
        if (extras) begin
            repeat (4) @(negedge clk);
            pulse(0);
            wait_kin(kin0, 10);
            chk("busy mid-FEED", 64'(busy), 1);
            pulse(1);
        end
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) fail("timeout waiting for done");
        repeat (3) @(negedge clk);
        chk("wt_rd_en cycles", 64'(wt_n - wt0), K*K+1);
        chk("k_in_valid pulses", 64'(kin_n - kin0), TOT);
        chk("result writes", 64'(wr_n - wr0), OW*OH);
        chk("done pulses", 64'(done_n - done0), 1);
        chk("scoreboard leftover", 64'(exp_q.size()), 0);
        chk("busy after pass", 64'(busy), 0);
    endtask

    initial begin
        int kin0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Pass 1: ramp feature map, weights j+1, bias 0x64, column-index kernel.
        for (int a = 0; a < IW*IH; a++) fm_mem[a] = DW'(a);
        for (int j = 0; j < K*K; j++) wt_mem[j] = DW'(j + 1);
        wt_mem[K*K] = 32'h64;
        kmode = 0;
        run_pass(1);

        // Pass 2: random data and signed weights through a real convolution,
        // plus a stray strobe beyond the issued count.
        for (int a = 0; a < IW*IH; a++) fm_mem[a] = DW'($urandom_range(0, 255));
        for (int j = 0; j < K*K; j++) wt_mem[j] = DW'($urandom_range(0, 20)) - 32'd10;
        wt_mem[K*K] = DW'($urandom_range(0, 4000)) - 32'd2000;
        kmode = 1;
        inject_extra = 1;
        run_pass(0);
        inject_extra = 0;

        // Pass 3: aborted by reset at column 3.
        for (int j = 0; j < K*K+1; j++) wt_mem[j] = $urandom;
        kmode = 0;
        pass_id++;
        push_expected();
        kin0 = kin_n;
        pulse(1);
        wait_kin(kin0, 3);
        rst_n = 1'b0;
        #1;
        check_zero("mid-pass reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass 4: negative kernel results, fresh pass from address 0.
        kmode = 2;
        run_pass(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

endmodule
